stoch_bitstream_decoder: RTL and testbench

Converts a unipolar stochastic bitstream back into a fixed-point binary value. It counts the ones over a window of 2^WINDOW_LOG2 accepted samples and presents the count on a ready/valid output. It sits at the output boundary of a stochastic datapath, after the SNG/decorrelator/arithmetic stages, and hands results to binary logic or a readback register.

---
 rtl/stoch_bitstream_decoder.sv | 112 +++++++++++
 tb/tb_stoch_bitstream_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stoch_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WINDOW_LOG2 accepted samples, result on y/y_valid/y_ready.
// Define STOCH_DECODE_SLIDING_EN for sliding-window mode (y_ready ignored, ovf tied low).
module stoch_bitstream_decoder #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   clear,
    input  logic                   en,
    input  logic                   a,
    output logic [WINDOW_LOG2:0]   y,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic                   ovf
);

    localparam int N = 1 << WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] IDX_LAST = '1;
    localparam logic [WINDOW_LOG2-1:0] IDX_ONE  = WINDOW_LOG2'(1);

    logic [WINDOW_LOG2:0]   acc;
    logic [WINDOW_LOG2-1:0] idx;
    logic [WINDOW_LOG2:0]   bit_ext;
    logic                   last;

    assign bit_ext = {{WINDOW_LOG2{1'b0}}, a};
    assign last    = (idx == IDX_LAST);

`ifdef STOCH_DECODE_SLIDING_EN

    logic [N-1:0]         sr;
    logic [WINDOW_LOG2:0] old_ext;
    logic [WINDOW_LOG2:0] acc_next;
    logic                 unused_ready;

    assign old_ext      = {{WINDOW_LOG2{1'b0}}, sr[N-1]};
    assign acc_next     = acc + bit_ext - old_ext;
    assign ovf          = 1'b0;
    assign unused_ready = y_ready;

    // idx only counts until the first fill; afterwards y_valid stands in for "window full".
    always_ff @(posedge CLK) begin
        if (!nRST || clear) begin
            sr      <= '0;
            acc     <= '0;
            idx     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else if (en) begin
            sr  <= {sr[N-2:0], a};
            acc <= acc_next;
            if (!y_valid) begin
                idx <= idx + IDX_ONE;
            end
            if (y_valid || last) begin
                y       <= acc_next;
                y_valid <= 1'b1;
            end
        end
    end

`else

    typedef enum logic {ACCUM, PEND} state_t;

    state_t               state;
    logic [WINDOW_LOG2:0] total;
    logic                 done;
    logic                 take;

    assign total = acc + bit_ext;
    assign done  = en && last;
    assign take  = (state == PEND) && y_ready;

    always_ff @(posedge CLK) begin
        if (!nRST || clear) begin
            acc     <= '0;
            idx     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            ovf     <= 1'b0;
            state   <= ACCUM;
        end else begin
            if (done) begin
                acc <= '0;
                idx <= '0;
                if (state == ACCUM) begin
                    y       <= total;
                    y_valid <= 1'b1;
                    state   <= PEND;
                end else if (y_ready) begin
                    // old result is consumed on this edge, new one replaces it with no gap
                    y <= total;
                end else begin
                    ovf <= 1'b1;
                end
            end else begin
                if (en) begin
                    acc <= total;
                    idx <= idx + IDX_ONE;
                end
                if (take) begin
                    y_valid <= 1'b0;
                    state   <= ACCUM;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_stoch_bitstream_decoder.sv
// Scoreboard bench for stoch_bitstream_decoder at WINDOW_LOG2=4 (N=16).
module tb_stoch_bitstream_decoder;

    localparam int W = 4;
    localparam int N = 16;

    logic         CLK;
    logic         nRST;
    logic         clear;
    logic         en;
    logic         a;
    logic [W:0]   y;
    logic         y_valid;
    logic         y_ready;
    logic         ovf;

    int n_cmp;
    int n_bad;

    stoch_bitstream_decoder #(.WINDOW_LOG2(W)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (clear),
        .en      (en),
        .a       (a),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .ovf     (ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // reference state
    int sbq[$];
    int ones;
    int cnt;
    bit pend;
    bit ovf_m;
    int hist[$];
    int seen;

    function automatic void model_reset();
        sbq.delete();
        hist.delete();
        ones  = 0;
        cnt   = 0;
        pend  = 0;
        ovf_m = 0;
        seen  = 0;
    endfunction

    function automatic int hist_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic do_reset();
        nRST = 1'b0; clear = 1'b0; en = 1'b1; a = 1'b1; y_ready = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b1; en = 1'b0; a = 1'b0; y_ready = 1'b0;
        model_reset();
        chk("rst_y", y, 0);
        chk("rst_vld", y_valid, 0);
        chk("rst_ovf", ovf, 0);
    endtask

    // one clock: drive inputs, settle, let the edge happen, compare #1 later
    task automatic step(input bit e, input bit b, input bit r, input bit clr);
        en = e; a = b; y_ready = r; clear = clr;
`ifndef STOCH_DECODE_SLIDING_EN
        if (y_valid && r && !clr) begin
            if (sbq.size() == 0) chk("sb_underflow", 1, 0);
            else chk("hs_y", y, sbq.pop_front());
        end
        if (clr) begin
            model_reset();
        end else if (e && cnt == N - 1) begin
            int total = ones + int'(b);
            ones = 0;
            cnt  = 0;
            if (!pend) begin
                sbq.push_back(total);
                pend = 1;
            end else if (r) begin
                sbq.push_back(total);
            end else begin
                ovf_m = 1;
            end
        end else begin
            if (e) begin
                ones += int'(b);
                cnt++;
            end
            if (pend && r) pend = 0;
        end
        @(posedge CLK); #1;
        chk("vld", y_valid, pend);
        chk("ovf", ovf, ovf_m);
        if (pend && sbq.size() > 0) chk("y_hold", y, sbq[0]);
`else
        if (clr) begin
            model_reset();
        end else if (e) begin
            hist.push_back(int'(b));
            if (hist.size() > N) void'(hist.pop_front());
            if (seen < N) seen++;
        end
        @(posedge CLK); #1;
        chk("vld", y_valid, seen >= N);
        chk("ovf", ovf, 0);
        if (seen >= N) chk("y_slide", y, hist_sum());
`endif
        if (clr) chk("clr_y", y, 0);
        en = 1'b0; a = 1'b0; y_ready = 1'b0; clear = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRST = 1'b1; clear = 1'b0; en = 1'b0; a = 1'b0; y_ready = 1'b0;
        model_reset();
        do_reset();
`ifndef STOCH_DECODE_SLIDING_EN
        // all ones -> y = N
        for (int i = 0; i < N; i++) step(1, 1, 0, 0);
        chk("t1_y", y, 16);
        chk("t1_vld", y_valid, 1);
        step(0, 0, 1, 0);
        // alternating, then all zeros
        for (int i = 0; i < N; i++) step(1, (i % 2) == 0, 0, 0);
        chk("t2_y", y, 8);
        step(0, 0, 1, 0);
        chk("t2_vld_drop", y_valid, 0);
        for (int i = 0; i < N; i++) step(1, 0, 0, 0);
        chk("t2_zero", y, 0);
        step(0, 0, 1, 0);
        // two windows unread -> overflow
        for (int i = 0; i < N; i++) step(1, 1, 0, 0);
        for (int i = 0; i < N; i++) step(1, 0, 0, 0);
        chk("t3_y", y, 16);
        chk("t3_ovf", ovf, 1);
        step(0, 0, 1, 0);
        chk("t3_ovf_sticky", ovf, 1);
        // sparse enables, then completion coinciding with handshake
        do_reset();
        for (int i = 0; i < 2 * N; i++) step(i % 2 == 0, 1, 0, 0);
        chk("t4_y", y, 16);
        for (int i = 0; i < N - 1; i++) step(1, i < 4, 0, 0);
        step(1, 1, 1, 0);
        chk("t4_y5", y, 5);
        chk("t4_vld", y_valid, 1);
        step(0, 0, 1, 0);
        // clear mid-window, on completion, and reset mid-window
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < N; i++) step(1, 1, 0, 0);
        chk("t5_y", y, 16);
        step(0, 0, 1, 0);
        for (int i = 0; i < N - 1; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        chk("t5_clr_vld", y_valid, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        do_reset();
`else
        for (int i = 0; i < N; i++) step(1, 1, 0, 0);
        chk("s_full", y, 16);
        step(1, 0, 0, 0);
        chk("s_drop", y, 15);
        step(0, 0, 0, 1);
        chk("s_clr_vld", y_valid, 0);
`endif
        // random traffic with rare clears
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
